// File: rtl/pc_sequencer.sv
// PC sequencer: steps the PC through an external adder, handles redirects, stalls and fetch backpressure.
// Optional misaligned-redirect trap is compiled in with `define PC_MISALIGN_TRAP_EN.
module pc_sequencer #(
    parameter int             n        = 16,
    parameter logic [n-1:0]   RESET_PC = {n{1'b0}},
    parameter int             INC      = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [n-1:0] pc,
    output logic [n-1:0] pc_inc,
    input  logic [n-1:0] pc_plus,
    input  logic         redirect_valid,
    input  logic [n-1:0] redirect_target,
    input  logic         stall,
    output logic         fetch_valid,
    input  logic         fetch_ready,
    output logic [n-1:0] fetch_pc,
    output logic [n-1:0] fetch_count,
    output logic         trap
);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        RUN    = 3'd1,
        HOLD   = 3'd2,
        BUBBLE = 3'd3,
        TRAP   = 3'd4
    } state_t;

    localparam logic [n-1:0] COUNT_ONE = {{(n-1){1'b0}}, 1'b1};

    state_t       state_r;
    logic [n-1:0] pc_r;
    logic [n-1:0] count_r;
    logic         fetch_valid_r;
    logic         trap_r;
    logic         xfer_s;
    logic         redirect_trap_s;
    state_t       redirect_state_s;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [n-1:0] ALIGN_MASK = n'(INC - 1);

    function automatic logic misaligned(input logic [n-1:0] target);
        misaligned = ((target & ALIGN_MASK) != {n{1'b0}});
    endfunction

    // A redirect to an address not aligned to INC diverts into TRAP.
    always_comb begin
        redirect_trap_s = 1'b0;
        if (redirect_valid) begin
            redirect_trap_s = misaligned(redirect_target);
        end else begin
            redirect_trap_s = 1'b0;
        end
    end
`else
    assign redirect_trap_s = 1'b0;
`endif

    assign xfer_s           = fetch_valid_r & fetch_ready;
    assign redirect_state_s = redirect_trap_s ? TRAP : BUBBLE;

    assign pc          = pc_r;
    assign pc_inc      = n'(INC);
    assign fetch_pc    = pc_r;
    assign fetch_valid = fetch_valid_r;
    assign fetch_count = count_r;
    assign trap        = trap_r;

    // Sequencer FSM: fetch_valid is high exactly while in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= BOOT;
            pc_r          <= RESET_PC;
            count_r       <= {n{1'b0}};
            fetch_valid_r <= 1'b0;
            trap_r        <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r       <= RUN;
                    fetch_valid_r <= 1'b1;
                end
                RUN: begin
                    // An accepted fetch counts even when the same edge redirects or stalls.
                    if (xfer_s) begin
                        count_r <= count_r + COUNT_ONE;
                    end else begin
                        count_r <= count_r;
                    end
                    if (redirect_valid) begin
                        pc_r          <= redirect_target;
                        state_r       <= redirect_state_s;
                        fetch_valid_r <= 1'b0;
                        trap_r        <= redirect_trap_s;
                    end else if (stall) begin
                        pc_r          <= xfer_s ? pc_plus : pc_r;
                        state_r       <= HOLD;
                        fetch_valid_r <= 1'b0;
                    end else begin
                        pc_r          <= xfer_s ? pc_plus : pc_r;
                        state_r       <= RUN;
                        fetch_valid_r <= 1'b1;
                    end
                end
                HOLD, BUBBLE: begin
                    if (redirect_valid) begin
                        pc_r          <= redirect_target;
                        state_r       <= redirect_state_s;
                        fetch_valid_r <= 1'b0;
                        trap_r        <= redirect_trap_s;
                    end else if (stall) begin
                        state_r       <= HOLD;
                        fetch_valid_r <= 1'b0;
                    end else begin
                        state_r       <= RUN;
                        fetch_valid_r <= 1'b1;
                    end
                end
                TRAP: begin
                    state_r       <= TRAP;
                    fetch_valid_r <= 1'b0;
                    trap_r        <= 1'b1;
                end
                default: begin
                    state_r       <= BOOT;
                    fetch_valid_r <= 1'b0;
                    trap_r        <= 1'b0;
                end
            endcase
        end
    end

endmodule
